muldiv_sequencer: RTL

Iterative signed multiply/divide engine and its sequencing FSM for the 16-bit core. Executes the R-type functionCode 0001 (signed multiply) and 0010 (signed divide) operations that write both Rd and r0. Stalls the core while it runs, then issues one-cycle regWrite/r0Write strobes with the low and high result words.

---
 rtl/muldiv_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply/divide sequencer (optional macro MULDIV_EARLY_OUT_EN)
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       functionCode,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             regWrite,
  output logic             r0Write,
  output logic [WIDTH-1:0] resultLo,
  output logic [WIDTH-1:0] resultHi,
  output logic             divByZero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic               div_q, div_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d, lo_q, lo_d, hi_q, hi_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               valid, accept, early, neg;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, fix_lo, fix_hi;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  assign valid  = (functionCode == 4'b0001) || (functionCode == 4'b0010);
  assign accept = start && valid && (state_q == IDLE);
  assign mag_a  = a_q[WIDTH-1] ? -a_q : a_q;
  assign mag_b  = b_q[WIDTH-1] ? -b_q : b_q;
  assign neg    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
`ifdef MULDIV_EARLY_OUT_EN
  assign early  = div_q ? (mag_a < mag_b) : ((a_q == '0) || (b_q == '0));
`else
  assign early  = 1'b0;
`endif
  // p_q holds {partial product hi, multiplier bits} or {remainder, dividend/quotient bits}
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{p_q[0]}} & m_q};
  assign div_sh   = p_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, m_q};
  assign div_ge   = div_sh >= {1'b0, m_q};
  assign prod     = neg ? -p_q : p_q;
  assign quo      = neg ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem      = a_q[WIDTH-1] ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  assign fix_lo   = dbz_q ? '1 : div_q ? quo : prod[WIDTH-1:0];
  assign fix_hi   = dbz_q ? a_q : div_q ? rem : prod[2*WIDTH-1:WIDTH];
  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      dbz_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dbz_q   <= dbz_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end
  // Next-state, iteration step and output strobes
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    dbz_d   = dbz_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = PREP;
        div_d   = functionCode[1];
        dbz_d   = 1'b0;
        a_d     = opA;
        b_d     = opB;
      end
      PREP: begin
        m_d     = div_q ? mag_b : mag_a;
        p_d     = div_q ? (early ? {mag_a, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, mag_a})
                        : (early ? '0 : {{WIDTH{1'b0}}, mag_b});
        cnt_d   = '0;
        dbz_d   = div_q && (b_q == '0);
        state_d = (dbz_d || early) ? FIX : RUN;
      end
      RUN: begin
        p_d     = div_q ? {div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0], p_q[WIDTH-2:0], div_ge}
                        : {mul_sum, p_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
      end
      FIX: begin
        lo_d    = fix_lo;
        hi_d    = fix_hi;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    stall     = accept || (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
    busy      = state_q != IDLE;
    done      = state_q == DONE;
    regWrite  = done;
    r0Write   = done;
    resultLo  = lo_q;
    resultHi  = hi_q;
    divByZero = dbz_q;
  end
endmodule
